// File: rtl/ahb_burst_master.sv
// ahb_burst_master: AHB-Lite master turning one command into a SINGLE/INCR/INCR4/8/16 burst
// Optional feature: define AHB_ERR_RESP_EN to add hresp/cmd_err slave error handling.
// Ports: hclk, hreset (sync, active high); cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_len/cmd_size
//   command handshake; wr_data/wr_pop write-data supply; rd_data/rd_valid read return; done
//   completion pulse; hready_out/hr_data (+hresp) from the slave; haddr/hwdata/hwrite/htrans/
//   hsize/hburst/hready_in to the bus (+cmd_err completion status).
module ahb_burst_master #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BEATS = 16,
    localparam int LW       = $clog2(MAX_BEATS) + 1
) (
    input  logic              hclk,
    input  logic              hreset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LW-1:0]     cmd_len,
    input  logic [2:0]        cmd_size,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              done,
    input  logic              hready_out,
    input  logic [DATA_W-1:0] hr_data,
`ifdef AHB_ERR_RESP_EN
    input  logic              hresp,
    output logic              cmd_err,
`endif
    output logic [ADDR_W-1:0] haddr,
    output logic [DATA_W-1:0] hwdata,
    output logic              hwrite,
    output logic [1:0]        htrans,
    output logic [2:0]        hsize,
    output logic [2:0]        hburst,
    output logic              hready_in
);
    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_SEQ, S_LAST} state_t;
    state_t r_state, w_next;
    logic [ADDR_W-1:0] r_haddr;
    logic [DATA_W-1:0] r_hwdata, r_rd_data;
    logic [1:0]        r_htrans;
    logic [2:0]        r_hsize, r_hburst;
    logic              r_hwrite, r_rd_valid, r_done;
    logic [LW-1:0]     r_left;
    logic              w_err, w_aphase, w_dphase, w_adone, w_rdone, w_abort;
    logic [LW-1:0]     w_len;
    logic [12:0]       w_end;
    logic [2:0]        w_burst;
    logic [ADDR_W-1:0] w_naddr;
`ifdef AHB_ERR_RESP_EN
    logic              r_cmd_err;
    assign w_err   = hresp;
    assign cmd_err = r_cmd_err;
`else
    assign w_err = 1'b0;
`endif
    // ADDR = first address phase only; SEQ = address phase overlapping a data phase;
    // LAST = final data phase with the bus already IDLE.
    assign w_aphase = (r_state == S_ADDR) || (r_state == S_SEQ);
    assign w_dphase = (r_state == S_SEQ) || (r_state == S_LAST);
    assign w_adone  = w_aphase & hready_out & ~w_err;
    assign w_rdone  = w_dphase & hready_out & ~w_err & ~r_hwrite;
    // First error cycle: drop the pending address phase and finish on the error's second cycle.
    assign w_abort  = (r_state == S_SEQ) & w_err & ~hready_out;
    assign w_len    = (cmd_len == '0) ? LW'(1) : cmd_len;
    // Byte offset one past the last beat within the starting 1 KB page.
    assign w_end    = 13'(cmd_addr[9:0]) + (13'(w_len) << cmd_size);
    assign w_burst  = (w_len == LW'(1)) ? 3'b000 :
                      (w_end > 13'd1024) ? 3'b001 :
                      (w_len == LW'(4)) ? 3'b011 :
                      (w_len == LW'(8)) ? 3'b101 :
                      (w_len == LW'(16)) ? 3'b111 : 3'b001;
    assign w_naddr  = r_haddr + (ADDR_W'(1) << r_hsize);
    always_ff @(posedge hclk) begin
        if (hreset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:        w_next = cmd_valid ? S_ADDR : S_IDLE;
            S_ADDR, S_SEQ: w_next = w_abort ? S_LAST : !w_adone ? r_state :
                                    (r_left != '0) ? S_SEQ : S_LAST;
            S_LAST:        w_next = hready_out ? S_IDLE : S_LAST;
            default:       w_next = S_IDLE;
        endcase
    end
    always_comb begin
        cmd_ready = r_state == S_IDLE;
        wr_pop    = w_adone & r_hwrite;
        hready_in = r_htrans != 2'b00;
    end
    always_ff @(posedge hclk) begin
        if (hreset) begin
            r_haddr    <= '0;
            r_hwdata   <= '0;
            r_rd_data  <= '0;
            r_htrans   <= 2'b00;
            r_hsize    <= '0;
            r_hburst   <= '0;
            r_hwrite   <= 1'b0;
            r_rd_valid <= 1'b0;
            r_done     <= 1'b0;
            r_left     <= '0;
`ifdef AHB_ERR_RESP_EN
            r_cmd_err  <= 1'b0;
`endif
        end else begin
            r_rd_valid <= w_rdone;
            r_done     <= (r_state == S_LAST) & hready_out;
`ifdef AHB_ERR_RESP_EN
            r_cmd_err  <= (r_state == S_LAST) & hready_out & hresp;
`endif
            if (w_rdone) r_rd_data <= hr_data;
            if (cmd_valid && cmd_ready) begin
                r_haddr  <= cmd_addr;
                r_htrans <= 2'b10;
                r_hwrite <= cmd_write;
                r_hsize  <= cmd_size;
                r_hburst <= w_burst;
                r_left   <= w_len - 1'b1;
            end
            if (w_abort) r_htrans <= 2'b00;
            if (w_adone) begin
                if (r_hwrite) r_hwdata <= wr_data;
                if (r_left != '0) begin
                    r_haddr  <= w_naddr;
                    // A beat opening a new 1 KB page restarts the transfer as NONSEQ.
                    r_htrans <= (w_naddr[9:0] == 10'd0) ? 2'b10 : 2'b11;
                    r_left   <= r_left - 1'b1;
                end else begin
                    r_htrans <= 2'b00;
                end
            end
        end
    end
    assign haddr    = r_haddr;
    assign hwdata   = r_hwdata;
    assign hwrite   = r_hwrite;
    assign htrans   = r_htrans;
    assign hsize    = r_hsize;
    assign hburst   = r_hburst;
    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign done     = r_done;
endmodule

// File: tb/tb_ahb_burst_master.sv
// tb_ahb_burst_master: directed table, reset and randomized checks of ahb_burst_master against a beat-level model
module tb_ahb_burst_master;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_write = 1'b0, hready_out = 1'b1;
    logic [31:0] cmd_addr = '0, wr_data = '0, hr_data = '0;
    logic [4:0]  cmd_len = '0;
    logic [2:0]  cmd_size = '0;
    logic        cmd_ready, wr_pop, rd_valid, done, hwrite, hready_in;
    logic [31:0] rd_data, haddr, hwdata;
    logic [1:0]  htrans;
    logic [2:0]  hsize, hburst;
`ifdef AHB_ERR_RESP_EN
    logic        hresp = 1'b0;
    logic        cmd_err;
`endif
    always #5 clk = ~clk;
    ahb_burst_master dut (
        .hclk(clk), .hreset(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size),
        .wr_data(wr_data), .wr_pop(wr_pop), .rd_data(rd_data), .rd_valid(rd_valid), .done(done),
        .hready_out(hready_out), .hr_data(hr_data),
`ifdef AHB_ERR_RESP_EN
        .hresp(hresp), .cmd_err(cmd_err),
`endif
        .haddr(haddr), .hwdata(hwdata), .hwrite(hwrite), .htrans(htrans), .hsize(hsize),
        .hburst(hburst), .hready_in(hready_in)
    );
    typedef struct {
        bit          w;
        logic [31:0] addr;
        logic [4:0]  len;
        logic [2:0]  size;
        int          waitc;
        logic [2:0]  burst;
        int          nonseq;
        int          xfers;
        logic [31:0] last;
        int          lat;
    } vec_t;
    int errors = 0, checks = 0;
    bit          busy = 0, m_write = 0, exp_done = 0, exp_rdv = 0;
    logic [31:0] m_addr0 = '0, exp_rdd = '0;
    logic [2:0]  m_size = '0;
    int          m_n = 1, a_idx = 0, dp = -1;
    logic [31:0] wdat [0:15];
    int          tcyc = 0, d_first = -1, d_done = -1, d_nonseq = 0, d_xfers = 0;
    logic [31:0] d_last = '0;
    function automatic logic [31:0] beat_addr(int i);
        return m_addr0 + (32'(i) << m_size);
    endfunction
    function automatic logic [1:0] beat_trans(int i);
        logic [31:0] a;
        a = beat_addr(i);
        return (i == 0 || a[9:0] == 10'd0) ? 2'b10 : 2'b11;
    endfunction
    function automatic logic [2:0] model_burst();
        logic [31:0] last;
        last = beat_addr(m_n - 1);
        if (m_n == 1) return 3'b000;
        if (last[31:10] != m_addr0[31:10]) return 3'b001;
        return (m_n == 4) ? 3'b011 : (m_n == 8) ? 3'b101 : (m_n == 16) ? 3'b111 : 3'b001;
    endfunction
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, tcyc);
        end
    endtask
    task automatic cycle(input bit rdy, input bit issue, input bit w, input logic [31:0] a,
                         input logic [4:0] l, input logic [2:0] s);
        bit was_idle, aphase;
        int nd;
        @(negedge clk);
        hready_out = rdy;
        hr_data    = $urandom;
        wr_data    = $urandom;
        cmd_valid  = issue;
        cmd_write  = w;
        cmd_addr   = a;
        cmd_len    = l;
        cmd_size   = s;
        #1;
        tcyc++;
        was_idle = !busy;
        aphase   = busy && a_idx < m_n;
        chk("cmd_ready", cmd_ready, was_idle);
        chk("done", done, exp_done);
        chk("rd_valid", rd_valid, exp_rdv);
        if (exp_rdv) chk("rd_data", rd_data, exp_rdd);
        chk("htrans", htrans, aphase ? beat_trans(a_idx) : 2'b00);
        chk("hready_in", hready_in, aphase);
        chk("wr_pop", wr_pop, aphase && rdy && m_write);
        if (aphase) begin
            chk("haddr", haddr, beat_addr(a_idx));
            chk("hburst", hburst, model_burst());
            chk("hsize", hsize, m_size);
            chk("hwrite", hwrite, m_write);
        end
        if (busy && dp >= 0 && rdy && m_write) chk("hwdata", hwdata, wdat[dp]);
        if (htrans == 2'b10) d_nonseq++;
        if (htrans == 2'b10 && d_first < 0) d_first = tcyc;
        if (htrans != 2'b00) d_last = haddr;
        if (done) d_done = tcyc;
        d_xfers += int'(wr_pop) + int'(rd_valid);
        exp_done = 0;
        exp_rdv  = 0;
        nd = dp;
        if (busy && rdy) begin
            if (dp >= 0) begin
                if (!m_write) begin
                    exp_rdv = 1;
                    exp_rdd = hr_data;
                end
                if (dp == m_n - 1) begin
                    exp_done = 1;
                    busy = 0;
                end
                nd = -1;
            end
            if (aphase) begin
                if (m_write) wdat[a_idx] = wr_data;
                nd = a_idx;
                a_idx++;
            end
        end
        dp = nd;
        if (issue && was_idle) begin
            busy    = 1;
            m_write = w;
            m_addr0 = a;
            m_n     = (l == 0) ? 1 : int'(l);
            m_size  = s;
            a_idx   = 0;
            dp      = -1;
        end
    endtask
    task automatic run_vec(input vec_t v, input string nm);
        int k;
        d_first = -1; d_done = -1; d_nonseq = 0; d_xfers = 0; d_last = '0;
        cycle(1, 1, v.w, v.addr, v.len, v.size);
        k = 1;
        while (busy && k < 200) begin
            cycle(k != v.waitc, 0, 0, '0, '0, '0);
            k++;
        end
        if (busy) begin
            errors++;
            $display("FAIL %s timeout: command still busy after %0d cycles", nm, k);
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $fatal(1, "bench stopped");
        end
        cycle(1, 0, 0, '0, '0, '0);
        chk({nm, " hburst"}, {29'd0, hburst}, {29'd0, v.burst});
        chk({nm, " nonseq count"}, d_nonseq, v.nonseq);
        chk({nm, " transfers"}, d_xfers, v.xfers);
        chk({nm, " last haddr"}, d_last, v.last);
        chk({nm, " latency"}, d_done - d_first, v.lat);
    endtask
    vec_t tab [9];
    vec_t fresh;
    logic [31:0] ra;
    logic [4:0]  rl;
    logic [2:0]  rs;
    int          k;
    int          pops;
    initial begin
        tab[0] = '{1, 32'h8000_0000, 5'd1,  3'd2, -1, 3'b000, 1, 1,  32'h8000_0000, 2};
        tab[1] = '{0, 32'h0000_0100, 5'd4,  3'd2,  2, 3'b011, 1, 4,  32'h0000_010C, 6};
        tab[2] = '{1, 32'h0000_03F8, 5'd4,  3'd2, -1, 3'b001, 2, 4,  32'h0000_0404, 5};
        tab[3] = '{0, 32'h0000_0010, 5'd7,  3'd0, -1, 3'b001, 1, 7,  32'h0000_0016, 8};
        tab[4] = '{1, 32'h0000_0000, 5'd0,  3'd1, -1, 3'b000, 1, 1,  32'h0000_0000, 2};
        tab[5] = '{0, 32'h0000_0200, 5'd16, 3'd2, -1, 3'b111, 1, 16, 32'h0000_023C, 17};
        tab[6] = '{1, 32'h0000_03E0, 5'd8,  3'd2, -1, 3'b101, 1, 8,  32'h0000_03FC, 9};
        tab[7] = '{1, 32'hFFFF_FFFC, 5'd2,  3'd2, -1, 3'b001, 2, 2,  32'h0000_0000, 3};
        tab[8] = '{0, 32'h0000_07F0, 5'd8,  3'd1,  5, 3'b101, 1, 8,  32'h0000_07FE, 10};
        fresh  = '{1, 32'h0000_0020, 5'd4,  3'd2, -1, 3'b011, 1, 4,  32'h0000_002C, 5};
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset htrans", htrans, 2'b00);
        chk("reset haddr", haddr, 32'd0);
        chk("reset hwdata", hwdata, 32'd0);
        chk("reset hburst", hburst, 3'd0);
        chk("reset done", done, 1'b0);
        chk("reset rd_valid", rd_valid, 1'b0);
        chk("reset hready_in", hready_in, 1'b0);
        chk("reset cmd_ready", cmd_ready, 1'b1);
        rst = 1'b0;
        for (int i = 0; i < 9; i++) run_vec(tab[i], $sformatf("vec%0d", i));
        cycle(1, 1, 1, 32'h0000_1000, 5'd8, 3'd2);
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, '0, '0, '0);
        @(negedge clk);
        rst = 1'b1;
        cmd_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("midrst htrans", htrans, 2'b00);
        chk("midrst haddr", haddr, 32'd0);
        chk("midrst hwdata", hwdata, 32'd0);
        chk("midrst hburst", hburst, 3'd0);
        chk("midrst hwrite", hwrite, 1'b0);
        chk("midrst done", done, 1'b0);
        chk("midrst wr_pop", wr_pop, 1'b0);
        chk("midrst cmd_ready", cmd_ready, 1'b1);
        rst = 1'b0;
        busy = 0; dp = -1; exp_done = 0; exp_rdv = 0;
        run_vec(fresh, "after_reset");
`ifdef AHB_ERR_RESP_EN
        pops = 0;
        @(negedge clk);
        cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h40; cmd_len = 5'd4; cmd_size = 3'd2;
        hready_out = 1; hresp = 0;
        #1 pops += int'(wr_pop);
        @(negedge clk);
        cmd_valid = 0;
        #1 pops += int'(wr_pop);
        @(negedge clk);
        #1 pops += int'(wr_pop);
        @(negedge clk);
        hready_out = 0; hresp = 1;
        #1 pops += int'(wr_pop);
        chk("err htrans beat3", htrans, 2'b11);
        @(negedge clk);
        hready_out = 1;
        #1 pops += int'(wr_pop);
        chk("err htrans idle", htrans, 2'b00);
        @(negedge clk);
        hresp = 0;
        #1;
        chk("err done", done, 1'b1);
        chk("err cmd_err", cmd_err, 1'b1);
        chk("err wr_pop count", pops, 2);
        cycle(1, 0, 0, '0, '0, '0);
`endif
        for (int c = 0; c < 3000; c++) begin
            rs = 3'($urandom_range(0, 2));
            rl = 5'($urandom_range(0, 16));
            ra = ($urandom_range(0, 1) == 1) ? 32'($urandom) :
                 (32'($urandom_range(1, 8)) << 10) - 32'($urandom_range(0, 40));
            ra = ra & ~((32'd1 << rs) - 32'd1);
            cycle($urandom_range(0, 9) < 7,
                  busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0),
                  $urandom_range(0, 1) == 1, ra, rl, rs);
        end
        k = 0;
        while (busy && k < 200) begin
            cycle(1, 0, 0, '0, '0, '0);
            k++;
        end
        if (busy) begin
            errors++;
            $display("FAIL drain timeout: command still busy");
        end
        cycle(1, 0, 0, '0, '0, '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks);
        $fatal(1, "watchdog");
    end
endmodule
